// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and constants for the SRAM controller
package sram_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DEF_ADDR_BASE   = 1024;
    localparam int DEF_WAIT_CYCLES = 5;
    localparam int SRAM_DW         = 16;

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage request/response bus to the SRAM controller
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access over a 16-bit asynchronous SRAM
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_BASE   = DEF_ADDR_BASE,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int CW = $clog2(WAIT_CYCLES);

    state_t             state;
    state_t             state_nxt;
    logic               request;
    logic               is_write;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata_q;
    logic [CW-1:0]      wait_cnt;
    logic [31:0]        read_data_q;
    logic               dq_oe;
    logic [SRAM_DW-1:0] dq_out;

    assign request = bus.rd_en | bus.wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (request) state_nxt = S_LO;
            S_LO:    state_nxt = S_HI;
            S_HI:    state_nxt = (WAIT_CYCLES == 3) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request is captured once so later input changes cannot disturb the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_write    <= 1'b0;
            word        <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            read_data_q <= '0;
        end else begin
            if (state == S_IDLE && request) begin
                is_write <= bus.wr_en;
                word     <= (SRAM_AW-1)'((bus.address - 32'(ADDR_BASE)) >> 2);
                wdata_q  <= bus.write_data;
            end
            if (state == S_HI) begin
                wait_cnt <= CW'(WAIT_CYCLES - 4);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == S_LO && !is_write) begin
                read_data_q[15:0] <= SRAM_DQ;
            end
            if (state == S_HI && !is_write) begin
                read_data_q[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            S_LO: begin
                SRAM_ADDR = {word, 1'b0};
                SRAM_WE_N = !is_write;
                dq_oe     = is_write;
                dq_out    = wdata_q[15:0];
            end
            S_HI: begin
                SRAM_ADDR = {word, 1'b1};
                SRAM_WE_N = !is_write;
                dq_oe     = is_write;
                dq_out    = wdata_q[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_DQ       = dq_oe ? dq_out : {SRAM_DW{1'bz}};
    assign bus.ready     = (state == S_IDLE && !request) || (state == S_DONE);
    assign bus.read_data = read_data_q;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_OE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - bench for sram_controller with a behavioural async SRAM
module sram_model #(
    parameter int AW = 18
) (
    inout  wire  [15:0]   dq,
    input  logic [AW-1:0] addr,
    input  logic          we_n,
    input  logic          ce_n,
    input  logic          oe_n,
    input  logic          ub_n,
    input  logic          lb_n
);

    logic [15:0]   mem [0:(1<<AW)-1];
    logic          ph_act  = 1'b0;
    logic [AW-1:0] ph_addr = '0;
    logic [15:0]   ph_data = '0;
    time           ph_t    = 0;

    assign dq = (we_n && !ce_n && !oe_n && !ub_n && !lb_n) ? mem[addr] : 16'hzzzz;

    // A write phase (stable address, WE low) commits only if it lasted long enough
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        forever begin
            @(addr or we_n);
            if (ph_act && ($time - ph_t) >= 3) mem[ph_addr] = ph_data;
            ph_act  = (we_n === 1'b0) && (ce_n === 1'b0);
            ph_addr = addr;
            ph_t    = $time;
        end
    end

    initial begin
        #5;
        forever begin
            if (ph_act) ph_data = dq;
            #10;
        end
    end

endmodule

module tb_sram_controller;

    localparam int WC = 5;
    localparam int AW = 18;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    wire  [15:0]   SRAM_DQ;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;
    int            checks = 0;
    int            errors = 0;
    vec_t          vecs [6];

    sram_controller_if bus ();

    sram_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(WC), .SRAM_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    sram_model #(.AW(AW)) u_sram (
        .dq   (SRAM_DQ),
        .addr (SRAM_ADDR),
        .we_n (SRAM_WE_N),
        .ce_n (SRAM_CE_N),
        .oe_n (SRAM_OE_N),
        .ub_n (SRAM_UB_N),
        .lb_n (SRAM_LB_N)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request at the next falling edge and samples cycles T..T+WC
    task automatic run_access(input int idx, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rdata);
        logic [WC:0]   rdy_mask;
        logic [WC:0]   we_mask;
        logic [AW-1:0] lo_addr;
        logic [AW-1:0] exp_addr;
        int            addr_bad;
        lo_addr  = AW'(((a - 32'd1024) >> 2) << 1);
        rdy_mask = '0;
        we_mask  = '0;
        addr_bad = 0;
        @(negedge clk);
        bus.rd_en      = rd;
        bus.wr_en      = wr;
        bus.address    = a;
        bus.write_data = wd;
        for (int k = 0; k <= WC; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            rdy_mask[k] = bus.ready;
            we_mask[k]  = !SRAM_WE_N;
            exp_addr    = (k == 1) ? lo_addr : (k == 2) ? (lo_addr | AW'(1)) : '0;
            if (SRAM_ADDR !== exp_addr) addr_bad++;
        end
        chk($sformatf("v%0d ready_seq", idx), 32'(rdy_mask), 32'b100000);
        chk($sformatf("v%0d we_n_seq", idx), 32'(we_mask), wr ? 32'b000110 : 32'b0);
        chk($sformatf("v%0d addr_seq", idx), 32'(addr_bad), 32'd0);
        chk($sformatf("v%0d read_data", idx), bus.read_data, exp_rdata);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'hFFFFFFFF, 32'hDEADBEEF, 16'hBEEF, 16'hDEAD};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 16'h5678, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'hFFFFFFFF, 32'h12345678, 16'h5678, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678, 16'hF00D, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b0, 32'd1032, 32'hFFFFFFFF, 32'hCAFEF00D, 16'hF00D, 16'hCAFE};

        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset ready", 32'(bus.ready), 32'd1);
        chk("reset we_n", 32'(SRAM_WE_N), 32'd1);
        chk("reset addr", 32'(SRAM_ADDR), 32'd0);
        chk("reset read_data", bus.read_data, 32'd0);

        for (int i = 0; i < 6; i++) begin
            int w;
            run_access(i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
            w = int'((vecs[i].addr - 32'd1024) >> 2);
            chk($sformatf("v%0d mem_lo", i), 32'(u_sram.mem[2*w]), 32'(vecs[i].exp_lo));
            chk($sformatf("v%0d mem_hi", i), 32'(u_sram.mem[2*w+1]), 32'(vecs[i].exp_hi));
        end
        chk("mem0 kept", 32'(u_sram.mem[0]), 32'h0000BEEF);
        chk("mem1 kept", 32'(u_sram.mem[1]), 32'h0000DEAD);

        // Reset lands early in the high-half write cycle of a store to 1036
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1036;
        bus.write_data = 32'h77778888;
        @(negedge clk);
        #1;
        chk("rst_seq lo we_n", 32'(SRAM_WE_N), 32'd0);
        chk("rst_seq lo addr", 32'(SRAM_ADDR), 32'd6);
        @(posedge clk);
        #1;
        chk("rst_seq hi addr", 32'(SRAM_ADDR), 32'd7);
        rst = 1'b0;
        #1;
        chk("rst_seq we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_seq addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_seq read_data", bus.read_data, 32'd0);
        bus.wr_en = 1'b0;
        #1;
        chk("rst_seq ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_seq mem6", 32'(u_sram.mem[6]), 32'h00008888);
        chk("rst_seq mem7", 32'(u_sram.mem[7]), 32'h00000000);
        run_access(6, 1'b1, 1'b0, 32'd1036, 32'hFFFFFFFF, 32'h00008888);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
